// File: rtl/adc_sync_fifo.sv
// adc_sync_fifo: single-clock sample FIFO for an ADC capture path.
// Supports standard registered reads or first-word-fall-through (FWFT) output,
// water-level tracking, almost-full/almost-empty thresholds and sticky
// overflow/underflow flags.
module adc_sync_fifo #(
    parameter int DATA_WIDTH       = 16,
    parameter int DEPTH_WIDTH      = 10,
    parameter int FWFT             = 0,
    parameter int ALMOST_FULL_NUM  = 1020,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   clr_err,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_valid,
    output logic                   wr_full,
    output logic                   rd_empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [DEPTH_WIDTH:0]   water_level,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0]   LVL_FULL = (DEPTH_WIDTH+1)'(DEPTH);
    localparam logic [DEPTH_WIDTH:0]   LVL_AF   = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
    localparam logic [DEPTH_WIDTH:0]   LVL_AE   = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);
    localparam logic [DEPTH_WIDTH:0]   LVL_ONE  = (DEPTH_WIDTH+1)'(1);
    localparam logic [DEPTH_WIDTH-1:0] PTR_ONE  = DEPTH_WIDTH'(1);

    // Threshold ordering must be sane for the flags to mean anything.
    if (!((ALMOST_EMPTY_NUM < ALMOST_FULL_NUM) && (ALMOST_FULL_NUM <= DEPTH))) begin : g_param_check
        $error("adc_sync_fifo: need ALMOST_EMPTY_NUM < ALMOST_FULL_NUM <= 2**DEPTH_WIDTH");
    end

    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
    logic [DEPTH_WIDTH-1:0] r_wr_ptr;
    logic [DEPTH_WIDTH-1:0] r_rd_ptr;
    logic [DEPTH_WIDTH:0]   r_level;
    logic                   r_overflow;
    logic                   r_underflow;

    logic                   w_full;
    logic                   w_wr_accept;
    logic                   w_pop;        // a word leaves the FIFO (level decrement)
    logic                   w_fetch;      // memory head is consumed (read pointer advance)
    logic                   w_rd_empty;
    logic                   w_rd_valid;
    logic [DATA_WIDTH-1:0]  w_rd_data;
    logic [DATA_WIDTH-1:0]  w_mem_rdata;

    // Full is judged on the registered level, so a full FIFO drops a write
    // even when a read frees a slot on the same edge.
    assign w_full      = (r_level == LVL_FULL);
    assign w_wr_accept = wr_en && !w_full;
    assign w_mem_rdata = r_mem[r_rd_ptr];

    // Storage array: written only on accepted writes, never cleared.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Write pointer advances on each accepted write and wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
        end else if (w_wr_accept) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
        end
    end

    // Read pointer advances whenever the memory head is pulled out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
        end else if (w_fetch) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Water level counts every word held, including FWFT staging registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
        end else begin
            case ({w_wr_accept, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky error flags; a fresh error on the clear cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && w_rd_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Two-stage prefetch: memory -> r_pf -> r_out. A word written at edge N
        // reaches r_pf at N+1 and the output at N+2; with both stages full a
        // held rd_en drains one word per cycle with no bubbles.
        logic                  r_pf_valid;
        logic [DATA_WIDTH-1:0] r_pf_data;
        logic                  r_out_valid;
        logic [DATA_WIDTH-1:0] r_out_data;
        logic                  w_out_load;
        logic [DEPTH_WIDTH:0]  w_mem_cnt;

        assign w_mem_cnt  = r_level - {{DEPTH_WIDTH{1'b0}}, r_out_valid}
                                    - {{DEPTH_WIDTH{1'b0}}, r_pf_valid};
        assign w_pop      = rd_en && r_out_valid;
        assign w_out_load = !r_out_valid || w_pop;
        assign w_fetch    = (!r_pf_valid || w_out_load) && (w_mem_cnt != '0);

        // Output stage and prefetch occupancy bookkeeping.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_out_valid <= 1'b0;
                r_out_data  <= '0;
                r_pf_valid  <= 1'b0;
            end else begin
                if (w_out_load) begin
                    r_out_valid <= r_pf_valid;
                    if (r_pf_valid) begin
                        r_out_data <= r_pf_data;
                    end
                end
                if (w_fetch) begin
                    r_pf_valid <= 1'b1;
                end else if (w_out_load) begin
                    r_pf_valid <= 1'b0;
                end
            end
        end

        // Prefetch data register captures the memory head when fetched.
        always_ff @(posedge clk) begin
            if (w_fetch) begin
                r_pf_data <= w_mem_rdata;
            end
        end

        assign w_rd_empty = !r_out_valid;
        assign w_rd_valid = r_out_valid;
        assign w_rd_data  = r_out_data;
    end else begin : g_std
        logic                  r_valid;
        logic [DATA_WIDTH-1:0] r_data;

        assign w_rd_empty = (r_level == '0);
        assign w_pop      = rd_en && !w_rd_empty;
        assign w_fetch    = w_pop;

        // Registered read: data appears one cycle after the accepted request.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else begin
                r_valid <= w_pop;
                if (w_pop) begin
                    r_data <= w_mem_rdata;
                end
            end
        end

        assign w_rd_valid = r_valid;
        assign w_rd_data  = r_data;
    end

    assign rd_data      = w_rd_data;
    assign rd_valid     = w_rd_valid;
    assign rd_empty     = w_rd_empty;
    assign wr_full      = w_full;
    assign almost_full  = (r_level >= LVL_AF);
    assign almost_empty = (r_level <= LVL_AE);
    assign water_level  = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_adc_sync_fifo.sv
// tb_adc_sync_fifo: drives a standard-mode and an FWFT-mode FIFO with the same
// stimulus and compares both against queue-based reference models.
module tb_adc_sync_fifo;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int CAP = 16;
    localparam int AFN = 14;
    localparam int AEN = 2;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          clr_err;
    logic          rd_en;

    logic [DW-1:0] s_rd_data, f_rd_data;
    logic          s_rd_valid, f_rd_valid;
    logic          s_full, f_full;
    logic          s_empty, f_empty;
    logic          s_af, f_af;
    logic          s_ae, f_ae;
    logic [AW:0]   s_level, f_level;
    logic          s_ovf, f_ovf;
    logic          s_udf, f_udf;

    adc_sync_fifo #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .FWFT(0),
                    .ALMOST_FULL_NUM(AFN), .ALMOST_EMPTY_NUM(AEN)) u_std (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .clr_err(clr_err), .rd_en(rd_en), .rd_data(s_rd_data),
        .rd_valid(s_rd_valid), .wr_full(s_full), .rd_empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .water_level(s_level),
        .overflow(s_ovf), .underflow(s_udf));

    adc_sync_fifo #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .FWFT(1),
                    .ALMOST_FULL_NUM(AFN), .ALMOST_EMPTY_NUM(AEN)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .clr_err(clr_err), .rd_en(rd_en), .rd_data(f_rd_data),
        .rd_valid(f_rd_valid), .wr_full(f_full), .rd_empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .water_level(f_level),
        .overflow(f_ovf), .underflow(f_udf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            e;
    } ent_t;

    // Reference state
    logic [DW-1:0] sq[$];
    ent_t          fq[$];
    logic [DW-1:0] m_s_data;
    logic          m_s_valid, m_s_ovf, m_s_udf;
    logic          m_f_valid, m_f_ovf, m_f_udf;
    int            edge_cnt;

    int n_err;
    int n_chk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sq.delete();
        fq.delete();
        m_s_data  = '0;
        m_s_valid = 1'b0;
        m_s_ovf   = 1'b0;
        m_s_udf   = 1'b0;
        m_f_valid = 1'b0;
        m_f_ovf   = 1'b0;
        m_f_udf   = 1'b0;
    endtask

    task automatic check_all(input string ph);
        chk({ph, ":std_level"}, 32'(s_level),    32'(sq.size()));
        chk({ph, ":std_full"},  32'(s_full),     32'(sq.size() == CAP));
        chk({ph, ":std_af"},    32'(s_af),       32'(sq.size() >= AFN));
        chk({ph, ":std_ae"},    32'(s_ae),       32'(sq.size() <= AEN));
        chk({ph, ":std_empty"}, 32'(s_empty),    32'(sq.size() == 0));
        chk({ph, ":std_valid"}, 32'(s_rd_valid), 32'(m_s_valid));
        chk({ph, ":std_data"},  32'(s_rd_data),  32'(m_s_data));
        chk({ph, ":std_ovf"},   32'(s_ovf),      32'(m_s_ovf));
        chk({ph, ":std_udf"},   32'(s_udf),      32'(m_s_udf));
        chk({ph, ":fw_level"},  32'(f_level),    32'(fq.size()));
        chk({ph, ":fw_full"},   32'(f_full),     32'(fq.size() == CAP));
        chk({ph, ":fw_af"},     32'(f_af),       32'(fq.size() >= AFN));
        chk({ph, ":fw_ae"},     32'(f_ae),       32'(fq.size() <= AEN));
        chk({ph, ":fw_valid"},  32'(f_rd_valid), 32'(m_f_valid));
        chk({ph, ":fw_empty"},  32'(f_empty),    32'(!m_f_valid));
        chk({ph, ":fw_ovf"},    32'(f_ovf),      32'(m_f_ovf));
        chk({ph, ":fw_udf"},    32'(f_udf),      32'(m_f_udf));
        if (m_f_valid) begin
            chk({ph, ":fw_data"}, 32'(f_rd_data), 32'(fq[0].d));
        end
    endtask

    // One clock cycle: drive inputs, advance the models at the edge, check 1ns later.
    task automatic step(input string ph, input logic w, input logic [DW-1:0] d,
                        input logic r, input logic c);
        logic s_was_full, s_was_empty, f_was_full, f_was_valid;
        ent_t e;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clr_err = c;
        @(posedge clk);
        edge_cnt++;
        // standard-mode rules
        s_was_full  = (sq.size() == CAP);
        s_was_empty = (sq.size() == 0);
        m_s_ovf = (w && s_was_full)  ? 1'b1 : (c ? 1'b0 : m_s_ovf);
        m_s_udf = (r && s_was_empty) ? 1'b1 : (c ? 1'b0 : m_s_udf);
        m_s_valid = 1'b0;
        if (r && !s_was_empty) begin
            m_s_data  = sq.pop_front();
            m_s_valid = 1'b1;
        end
        if (w && !s_was_full) sq.push_back(d);
        // FWFT rules: a word is shown from two edges after its write, once it is the head
        f_was_full  = (fq.size() == CAP);
        f_was_valid = m_f_valid;
        m_f_ovf = (w && f_was_full)   ? 1'b1 : (c ? 1'b0 : m_f_ovf);
        m_f_udf = (r && !f_was_valid) ? 1'b1 : (c ? 1'b0 : m_f_udf);
        if (r && f_was_valid) e = fq.pop_front();
        if (w && !f_was_full) begin
            e.d = d;
            e.e = edge_cnt;
            fq.push_back(e);
        end
        m_f_valid = (fq.size() > 0) && (fq[0].e + 2 <= edge_cnt);
        #1;
        check_all(ph);
    endtask

    initial begin
        n_err    = 0;
        n_chk    = 0;
        edge_cnt = 0;
        rst_n    = 1'b1;
        wr_en    = 1'b0;
        wr_data  = '0;
        rd_en    = 1'b0;
        clr_err  = 1'b0;
        model_reset();

        // power-on reset
        #2 rst_n = 1'b0;
        #2 check_all("reset");
        @(posedge clk);
        #1 check_all("reset_edge");
        rst_n = 1'b1;

        // fill to full, then overflow attempt and delayed clear
        for (int i = 1; i <= 16; i++) step("fill", 1'b1, DW'(i), 1'b0, 1'b0);
        step("wr17", 1'b1, 16'h0011, 1'b0, 1'b0);
        step("idle", 1'b0, '0, 1'b0, 1'b0);
        step("clr", 1'b0, '0, 1'b0, 1'b1);
        step("idle", 1'b0, '0, 1'b0, 1'b0);

        // drain all 16 in order, then read on empty
        for (int i = 0; i < 16; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
        step("rd_empty", 1'b0, '0, 1'b1, 1'b0);
        step("clr2", 1'b0, '0, 1'b0, 1'b1);

        // FWFT latency and back-to-back pops
        step("a5", 1'b1, 16'hA5A5, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("a5_wait", 1'b0, '0, 1'b0, 1'b0);
        step("a5_pop", 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step("q5", 1'b1, 16'hB000 + DW'(i), 1'b0, 1'b0);
        step("idle", 1'b0, '0, 1'b0, 1'b0);
        step("idle", 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step("burst", 1'b0, '0, 1'b1, 1'b0);
        step("clr3", 1'b0, '0, 1'b0, 1'b1);

        // steady level 8 with simultaneous traffic, pointers wrap repeatedly
        for (int i = 0; i < 8; i++) step("lvl8_fill", 1'b1, DW'($urandom), 1'b0, 1'b0);
        step("idle", 1'b0, '0, 1'b0, 1'b0);
        step("idle", 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) step("lvl8", 1'b1, DW'($urandom), 1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 300; i++)
            step("rand", 1'($urandom_range(0, 99) < 55), DW'($urandom),
                 1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 15) == 0));

        // empty it, then reset at level 9
        for (int i = 0; i < 20; i++) step("drain2", 1'b0, '0, 1'b1, 1'b0);
        step("clr4", 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) step("lvl9", 1'b1, 16'hC000 + DW'(i), 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("midreset");
        rst_n = 1'b1;
        step("post_wr", 1'b1, 16'h1234, 1'b0, 1'b0);
        step("idle", 1'b0, '0, 1'b0, 1'b0);
        step("idle", 1'b0, '0, 1'b0, 1'b0);
        step("post_rd", 1'b0, '0, 1'b1, 1'b0);
        step("idle", 1'b0, '0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/adc_sync_fifo.md
ADC_SYNC_FIFO -- requirements
Module: adc_sync_fifo

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Parameter DATA_WIDTH, default 16, word width in bits.
REQ-003 Parameter DEPTH_WIDTH, default 10; capacity is 2^DEPTH_WIDTH words.
REQ-004 Parameter FWFT, default 0; 0 = standard read, 1 = first-word-fall-through.
REQ-005 Parameter ALMOST_FULL_NUM, default 1020, almost_full threshold in words.
REQ-006 Parameter ALMOST_EMPTY_NUM, default 4, almost_empty threshold in words.
REQ-007 clk  in  1  sole clock; all state updates on its rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 wr_en  in  1  write request.
REQ-010 wr_data  in  DATA_WIDTH  write word.
REQ-011 clr_err  in  1  clears the sticky error flags.
REQ-012 rd_en  in  1  read request (standard mode) or pop (FWFT mode).
REQ-013 rd_data  out  DATA_WIDTH  read word.
REQ-014 rd_valid  out  1  rd_data holds a valid word.
REQ-015 wr_full  out  1  FIFO full.
REQ-016 rd_empty  out  1  no word available to the reader.
REQ-017 almost_full / almost_empty  out  1 each  threshold flags.
REQ-018 water_level  out  DEPTH_WIDTH+1  words held.
REQ-019 overflow / underflow  out  1 each  sticky error flags.

Function
REQ-020 A write SHALL be accepted when wr_en=1 and wr_full=0; otherwise it SHALL be dropped, with memory and pointers unchanged.
REQ-021 Write and read pointers SHALL be DEPTH_WIDTH bits wide and wrap from 2^DEPTH_WIDTH-1 to 0.
REQ-022 water_level SHALL count every stored word, including any word held in the FWFT output register.
REQ-023 water_level SHALL be +1 on a write-only edge, -1 on a read-only edge, and unchanged on a simultaneous accepted write and read.
REQ-024 wr_full SHALL equal (water_level == 2^DEPTH_WIDTH).
REQ-025 almost_full SHALL equal (water_level >= ALMOST_FULL_NUM).
REQ-026 almost_empty SHALL equal (water_level <= ALMOST_EMPTY_NUM).
REQ-027 All flags SHALL be derived only from registered state.
REQ-028 Standard mode: rd_empty SHALL equal (water_level == 0).
REQ-029 Standard mode: a read SHALL be accepted when rd_en=1 and rd_empty=0.
REQ-030 Standard mode: on the edge after an accepted read, rd_data SHALL hold the head word and rd_valid SHALL be 1 for exactly that one cycle; otherwise rd_data SHALL hold its last value.
REQ-031 FWFT mode: the head word SHALL be prefetched into an output register.
REQ-032 FWFT mode: rd_empty SHALL equal NOT rd_valid.
REQ-033 FWFT mode: rd_data SHALL present the head word while rd_valid=1.
REQ-034 FWFT mode: rd_en with rd_valid=1 SHALL pop the head word, with the next word, if present, shown on the following cycle with no bubble.
REQ-035 FWFT mode: for a write into an empty FIFO on edge N, rd_valid SHALL rise at edge N+2.
REQ-036 When full, wr_en and an accepted read on the same edge SHALL result in the read proceeding and the write being dropped.
REQ-037 When empty, rd_en and wr_en on the same edge SHALL result in the write being accepted and the read being rejected.
REQ-038 overflow SHALL set on the edge after wr_en=1 with wr_full=1.
REQ-039 underflow SHALL set on the edge after rd_en=1 with rd_empty=1.
REQ-040 overflow and underflow SHALL clear on the edge after clr_err=1, except that a same-cycle new error event SHALL win and keep the flag set.
REQ-041 The block SHALL be elaborated only with ALMOST_EMPTY_NUM < ALMOST_FULL_NUM <= 2^DEPTH_WIDTH.

Reset
REQ-042 While rst_n=0, the outputs SHALL be: pointers=0, water_level=0, rd_empty=1, almost_empty=1, wr_full=0, almost_full=0, rd_valid=0, rd_data=0, overflow=0, underflow=0.
REQ-043 Reset asserted mid-operation SHALL discard all stored words immediately; memory contents need not be cleared.
REQ-044 The first write SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
Benches use DATA_WIDTH=16, DEPTH_WIDTH=4, ALMOST_FULL_NUM=14, ALMOST_EMPTY_NUM=2.
REQ-045 Standard mode: write 0x0001..0x0010 (16 words) -> wr_full=1, almost_full=1, water_level=16; then read 16 -> data 0x0001..0x0010 in order, each one cycle after its rd_en, rd_empty=1 after the last read.
REQ-046 Standard mode, full: a 17th write plus clr_err two cycles later -> overflow=1, word 0x0011 never read back, overflow returns to 0 after clr_err.
REQ-047 FWFT mode: write 0xA5A5 at edge N -> rd_valid=1 and rd_data=0xA5A5 from edge N+2; hold rd_en=1 over 5 queued words -> 5 consecutive valid words, no gaps.
REQ-048 Simultaneous accepted write and read at water_level=8 over 100 cycles -> water_level stays 8, pointers wrap several times, data order preserved.
REQ-049 Threshold boundaries -> almost_empty=1 at levels 0..2 and 0 at 3; almost_full=0 at 13 and 1 at 14.
REQ-050 Reset at level 9 -> level 0, rd_empty=1, rd_valid=0, flags cleared; a subsequent write/read returns the new data only.
